// File: rtl/rca_seq_ctrl_if.sv
// rca_seq_ctrl_if: request/response handshake bundle for rca_seq_ctrl.
//   master : requester side (drives operands and out_ready)
//   slave  : controller side (drives in_ready and the result)
// Signals: in_valid/in_ready/in_a/in_b/in_cin (operand handshake),
//          out_valid/out_ready/out_sum/out_cout (result handshake).
// Optional macro RCA_SEQ_OVF_EN adds out_ovf (signed overflow flag).
interface rca_seq_ctrl_if #(
  parameter int N     = 4,
  parameter int WORDS = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [N*WORDS-1:0] in_a;
  logic [N*WORDS-1:0] in_b;
  logic               in_cin;
  logic               out_valid;
  logic               out_ready;
  logic [N*WORDS-1:0] out_sum;
  logic               out_cout;
`ifdef RCA_SEQ_OVF_EN
  logic               out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
`endif
endinterface

// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: word-serial wide adder sequencer. Computes an N*WORDS-bit
// sum by driving one external N-bit ripple-carry slice a word per cycle,
// least significant word first, keeping the inter-word carry in a flop.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   io (slave)        operand handshake in, result handshake out
//   busy              high while an operation is running or awaiting pickup
//   add_a/add_b/add_cin  slice operands/carry to the external adder
//   add_sum/add_cout     combinational slice result from the external adder
// Optional macro RCA_SEQ_OVF_EN: adds io.out_ovf, the two's-complement
// overflow of the W-bit add, held alongside out_sum.
module rca_seq_ctrl #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  rca_seq_ctrl_if.slave     io,
  output logic              busy,
  output logic [N-1:0]      add_a,
  output logic [N-1:0]      add_b,
  output logic              add_cin,
  input  logic [N-1:0]      add_sum,
  input  logic              add_cout
);
  localparam int W     = N * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               last_word;
`ifdef RCA_SEQ_OVF_EN
  logic               ovf_q, ovf_d;
  logic               carry_into_msb;
`endif

  assign last_word = (idx_q == IDX_W'(WORDS - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
`ifdef RCA_SEQ_OVF_EN
    ovf_d          = ovf_q;
    // Carry into bit W-1 recovered from the top slice's sum bit.
    carry_into_msb = a_q[W-1] ^ b_q[W-1] ^ add_sum[N-1];
`endif
    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          a_d     = io.in_a;
          b_d     = io.in_b;
          carry_d = io.in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*N +: N] = add_sum;
        carry_d             = add_cout;
        if (last_word) begin
          cout_d  = add_cout;
`ifdef RCA_SEQ_OVF_EN
          ovf_d   = carry_into_msb ^ add_cout;
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
`ifdef RCA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
`ifdef RCA_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Handshake outputs decode only the state flop: no input-to-output path.
  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign io.out_sum   = sum_q;
  assign io.out_cout  = cout_q;
`ifdef RCA_SEQ_OVF_EN
  assign io.out_ovf   = ovf_q;
`endif

  assign add_a   = (state_q == RUN) ? a_q[idx_q*N +: N] : '0;
  assign add_b   = (state_q == RUN) ? b_q[idx_q*N +: N] : '0;
  assign add_cin = (state_q == RUN) ? carry_q : 1'b0;
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl (N=4, WORDS=4) plus a WORDS=1 instance.
module tb_rca_seq_ctrl;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  // Main DUT: N=4, WORDS=4
  rca_seq_ctrl_if #(.N(4), .WORDS(4)) io ();
  logic       busy;
  logic [3:0] add_a, add_b, add_sum;
  logic       add_cin, add_cout;
  logic [4:0] slice;

  rca_seq_ctrl #(.N(4), .WORDS(4)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io       (io.slave),
    .busy     (busy),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  assign slice    = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
  assign add_sum  = slice[3:0];
  assign add_cout = slice[4];

  // Boundary DUT: N=8, WORDS=1
  rca_seq_ctrl_if #(.N(8), .WORDS(1)) io1 ();
  logic       busy1;
  logic [7:0] add_a1, add_b1, add_sum1;
  logic       add_cin1, add_cout1;
  logic [8:0] slice1;

  rca_seq_ctrl #(.N(8), .WORDS(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .io       (io1.slave),
    .busy     (busy1),
    .add_a    (add_a1),
    .add_b    (add_b1),
    .add_cin  (add_cin1),
    .add_sum  (add_sum1),
    .add_cout (add_cout1)
  );

  assign slice1    = {1'b0, add_a1} + {1'b0, add_b1} + {8'b0, add_cin1};
  assign add_sum1  = slice1[7:0];
  assign add_cout1 = slice1[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operand pair for one cycle; returns just after the accept edge.
  task automatic start(input logic [15:0] a, input logic [15:0] b, input logic cin);
    io.in_valid = 1'b1;
    io.in_a     = a;
    io.in_b     = b;
    io.in_cin   = cin;
    tick();
    io.in_valid = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n        = 1'b0;
    io.in_valid  = 1'b0;
    io.in_a      = '0;
    io.in_b      = '0;
    io.in_cin    = 1'b0;
    io.out_ready = 1'b0;
    io1.in_valid  = 1'b0;
    io1.in_a      = '0;
    io1.in_b      = '0;
    io1.in_cin    = 1'b0;
    io1.out_ready = 1'b0;
    #2;
    chk("rst_in_ready",  32'(io.in_ready), 32'h1);
    chk("rst_out_valid", 32'(io.out_valid), 32'h0);
    chk("rst_out_sum",   32'(io.out_sum), 32'h0);
    chk("rst_out_cout",  32'(io.out_cout), 32'h0);
    chk("rst_busy",      32'(busy), 32'h0);
    chk("rst_add_bus",   32'({add_a, add_b, add_cin}), 32'h0);
`ifdef RCA_SEQ_OVF_EN
    chk("rst_out_ovf",   32'(io.out_ovf), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // out_ready while idle has no effect
    io.out_ready = 1'b1;
    tick();
    chk("idle_ready_noeffect", 32'({io.in_ready, io.out_valid, busy}), 32'b100);
    io.out_ready = 1'b0;

    // 0xFFFF + 0x0001: carry ripples through every word
    start(16'hFFFF, 16'h0001, 1'b0);
    chk("t1_busy_in_ready", 32'({busy, io.in_ready}), 32'b10);
    chk("t1_cin0", 32'(add_cin), 32'h0);
    chk("t1_a0",   32'(add_a), 32'hF);
    tick();
    chk("t1_cin1", 32'(add_cin), 32'h1);
    tick();
    chk("t1_cin2", 32'(add_cin), 32'h1);
    tick();
    chk("t1_cin3", 32'(add_cin), 32'h1);
    chk("t1_not_yet_valid", 32'(io.out_valid), 32'h0);
    tick();
    chk("t1_out_valid", 32'(io.out_valid), 32'h1);
    chk("t1_out_sum",   32'(io.out_sum), 32'h0000);
    chk("t1_out_cout",  32'(io.out_cout), 32'h1);
    chk("t1_add_idle",  32'({add_a, add_b, add_cin}), 32'h0);
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
    chk("t1_back_idle", 32'({io.in_ready, io.out_valid, busy}), 32'b100);
    chk("t1_sum_kept",  32'(io.out_sum), 32'h0000);

    // 0x1234 + 0x4321 + 1 = 0x5556
    start(16'h1234, 16'h4321, 1'b1);
    chk("t2_a0", 32'(add_a), 32'h4);
    tick();
    chk("t2_a1", 32'(add_a), 32'h3);
    tick();
    chk("t2_a2", 32'(add_a), 32'h2);
    tick();
    chk("t2_a3", 32'(add_a), 32'h1);
    tick();
    chk("t2_out_sum",  32'(io.out_sum), 32'h5556);
    chk("t2_out_cout", 32'(io.out_cout), 32'h0);
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;

    // Backpressure: 0x0F0F held while out_ready is low
    start(16'h0F0F, 16'h0000, 1'b0);
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid",    32'(io.out_valid), 32'h1);
      chk("t3_hold_sum",      32'(io.out_sum), 32'h0F0F);
      chk("t3_hold_in_ready", 32'(io.in_ready), 32'h0);
      tick();
    end
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
    chk("t3_release", 32'({io.in_ready, io.out_valid}), 32'b10);

    // in_valid during RUN is ignored
    start(16'h1111, 16'h2222, 1'b0);
    tick();
    io.in_valid = 1'b1;
    io.in_a     = 16'hAAAA;
    io.in_b     = 16'h5555;
    tick();
    io.in_valid = 1'b0;
    chk("t4_a2_unchanged", 32'(add_a), 32'h1);
    tick();
    tick();
    chk("t4_out_sum",  32'(io.out_sum), 32'h3333);
    chk("t4_out_cout", 32'(io.out_cout), 32'h0);
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
    tick();
    chk("t4_stays_idle", 32'({io.in_ready, busy}), 32'b10);

    // Reset while RUN at idx=2
    start(16'h5555, 16'h5555, 1'b1);
    tick();
    tick();
    chk("t5_at_idx2", 32'(add_a), 32'h5);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_state", 32'({io.in_ready, io.out_valid, busy}), 32'b100);
    chk("t5_rst_sum",   32'(io.out_sum), 32'h0);
    chk("t5_rst_add",   32'({add_a, add_b, add_cin}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t5_no_valid", 32'(io.out_valid), 32'h0);
    start(16'h0001, 16'h0001, 1'b0);
    repeat (4) tick();
    chk("t5_new_sum", 32'(io.out_sum), 32'h0002);
    chk("t5_new_valid", 32'(io.out_valid), 32'h1);
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;

    // WORDS=1: 0xFF + 0x01 + 1 -> 0x01, cout 1, after a single RUN cycle
    io1.in_valid = 1'b1;
    io1.in_a     = 8'hFF;
    io1.in_b     = 8'h01;
    io1.in_cin   = 1'b1;
    tick();
    io1.in_valid = 1'b0;
    chk("w1_run", 32'({busy1, io1.out_valid, add_a1}), 32'({1'b1, 1'b0, 8'hFF}));
    tick();
    chk("w1_out_valid", 32'(io1.out_valid), 32'h1);
    chk("w1_out_sum",   32'(io1.out_sum), 32'h01);
    chk("w1_out_cout",  32'(io1.out_cout), 32'h1);
    io1.out_ready = 1'b1;
    tick();
    io1.out_ready = 1'b0;
    chk("w1_idle", 32'({io1.in_ready, io1.out_valid}), 32'b10);

`ifdef RCA_SEQ_OVF_EN
    start(16'h7FFF, 16'h0001, 1'b0);
    repeat (4) tick();
    chk("ovf1_sum", 32'(io.out_sum), 32'h8000);
    chk("ovf1_ovf", 32'(io.out_ovf), 32'h1);
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
    chk("ovf1_held", 32'(io.out_ovf), 32'h1);
    start(16'hFFFF, 16'h0001, 1'b0);
    repeat (4) tick();
    chk("ovf2_ovf",  32'(io.out_ovf), 32'h0);
    chk("ovf2_cout", 32'(io.out_cout), 32'h1);
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
